// File: rtl/rv32i_pkg.sv
// Shared rv32i_core types: write-back source select and load funct3 codes.
// Imported by the MEM/WB stage and the load alignment helper.
package rv32i_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks byte/halfword/word from an aligned
// memory word and sign/zero-extends it; flags misaligned accesses.
// Ports: word (raw 32b), funct3 (size/sign), offset (addr[1:0]) ->
//        data32 (extended value), misalign (only with MEM_WB_MISALIGN_CHECK_EN).
module load_align
    import rv32i_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data32,
    output logic        misalign
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        unique case (offset)
            2'd0: byte_v = word[7:0];
            2'd1: byte_v = word[15:8];
            2'd2: byte_v = word[23:16];
            2'd3: byte_v = word[31:24];
            default: byte_v = word[7:0];
        endcase
        // Halfword selection ignores offset[0]; misalignment is flagged separately.
        half_v = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data32 = word;
        case (funct3)
            F3_LB:   data32 = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  data32 = {24'h0, byte_v};
            F3_LH:   data32 = {{16{half_v[15]}}, half_v};
            F3_LHU:  data32 = {16'h0, half_v};
            default: data32 = word;
        endcase
    end

`ifdef MEM_WB_MISALIGN_CHECK_EN
    always_comb begin
        misalign = (((funct3 == F3_LH) || (funct3 == F3_LHU)) && offset[0])
                 || ((funct3 == F3_LW) && (offset != 2'd0));
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: selects write-back data, registers the
// register-file write port and counts retired instructions.
// Inputs: clk, rst (sync, active-high), stall, flush, mem_* MEM-stage bundle.
// Outputs: wb_valid, wb_reg_write, wb_rd, wb_write_data, wb_misalign, instret.
// Optional: MEM_WB_MISALIGN_CHECK_EN drops misaligned LH/LHU/LW writes.
module mem_wb_stage
    import rv32i_pkg::*;
#(
    parameter int RET_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_pc_plus4,
    input  logic [31:0]      mem_load_data,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_write_data,
    output logic             wb_misalign,
    output logic [RET_W-1:0] instret
);

    logic [31:0] load_val;
    logic        load_mis;
    logic        misalign;
    logic [31:0] sel_data;

    logic             valid_d, valid_q;
    logic             reg_write_d, reg_write_q;
    logic [4:0]       rd_d, rd_q;
    logic [31:0]      data_d, data_q;
    logic             mis_d, mis_q;
    logic [RET_W-1:0] instret_d, instret_q;

    load_align u_load_align (
        .word     (mem_load_data),
        .funct3   (mem_funct3),
        .offset   (mem_alu_result[1:0]),
        .data32   (load_val),
        .misalign (load_mis)
    );

    // Only a real load can be misaligned; ALU/link results never are.
    assign misalign = load_mis && (mem_wb_sel == WB_LOAD);

    always_comb begin
        case (wb_sel_t'(mem_wb_sel))
            WB_LOAD: sel_data = load_val;
            WB_PC4:  sel_data = mem_pc_plus4;
            default: sel_data = mem_alu_result;
        endcase
    end

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        data_d      = data_q;
        mis_d       = mis_q;
        instret_d   = instret_q;
        if (flush) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            rd_d        = 5'd0;
            data_d      = 32'd0;
            mis_d       = 1'b0;
        end else if (!stall) begin
            valid_d     = mem_valid;
            reg_write_d = mem_valid && mem_reg_write
                        && (mem_rd != 5'd0) && !misalign;
            rd_d        = mem_rd;
            data_d      = sel_data;
            mis_d       = mem_valid && misalign;
            // Dropped misaligned loads still retire.
            if (mem_valid)
                instret_d = instret_q + RET_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= 5'd0;
            data_q      <= 32'd0;
            mis_q       <= 1'b0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            data_q      <= data_d;
            mis_q       <= mis_d;
            instret_q   <= instret_d;
        end
    end

    assign wb_valid      = valid_q;
    assign wb_reg_write  = reg_write_q;
    assign wb_rd         = rd_q;
    assign wb_write_data = data_q;
    assign wb_misalign   = mis_q;
    assign instret       = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, hand-written
// stall/flush/misalign/reset sequences and random traffic vs a reference model.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_pc_plus4, mem_load_data;
    logic        wb_valid, wb_reg_write, wb_misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_write_data;
    logic [63:0] instret;

    int n_pass = 0;
    int n_total = 0;

    // reference model state
    bit          m_valid, m_rw, m_mis;
    bit [4:0]    m_rd;
    bit [31:0]   m_data;
    longint unsigned m_cnt;

    always #5 clk = ~clk;

    mem_wb_stage #(.RET_W(64)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_rd(mem_rd), .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
        .mem_alu_result(mem_alu_result), .mem_pc_plus4(mem_pc_plus4),
        .mem_load_data(mem_load_data),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
        .wb_write_data(wb_write_data), .wb_misalign(wb_misalign),
        .instret(instret)
    );

    typedef struct {
        bit        valid;
        bit        rw;
        bit [4:0]  rd;
        bit [1:0]  sel;
        bit [2:0]  f3;
        bit [31:0] alu;
        bit [31:0] pc4;
        bit [31:0] ld;
        bit [31:0] exp_data;
        bit        exp_rw;
        bit        exp_valid;
        longint unsigned exp_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input bit v, input bit rw,
                           input bit [4:0] rd, input bit [31:0] d,
                           input bit mis, input longint unsigned cnt);
        chk({tag, ".valid"}, 64'(wb_valid), 64'(v));
        chk({tag, ".reg_write"}, 64'(wb_reg_write), 64'(rw));
        chk({tag, ".rd"}, 64'(wb_rd), 64'(rd));
        chk({tag, ".data"}, 64'(wb_write_data), 64'(d));
        chk({tag, ".misalign"}, 64'(wb_misalign), 64'(mis));
        chk({tag, ".instret"}, instret, cnt);
    endtask

    function automatic bit [31:0] ref_extract(bit [31:0] w, bit [2:0] f3,
                                              int unsigned off);
        longint b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return 32'(b >= 128 ? b - 256 : b);
            3'd4: return 32'(b);
            3'd1: return 32'(h >= 32768 ? h - 65536 : h);
            3'd5: return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic bit ref_misalign(bit [1:0] sel, bit [2:0] f3,
                                        int unsigned off);
`ifdef MEM_WB_MISALIGN_CHECK_EN
        if (sel != 2'd1) return 1'b0;
        if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) return 1'b1;
        if (f3 == 3'd2 && off != 0) return 1'b1;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        int unsigned off;
        bit mis;
        off = int'(mem_alu_result % 4);
        mis = ref_misalign(mem_wb_sel, mem_funct3, off);
        if (rst) begin
            m_valid = 0; m_rw = 0; m_mis = 0; m_rd = 0; m_data = 0; m_cnt = 0;
        end else if (flush) begin
            m_valid = 0; m_rw = 0; m_mis = 0; m_rd = 0; m_data = 0;
        end else if (!stall) begin
            m_valid = mem_valid;
            m_rw = mem_valid && mem_reg_write && mem_rd != 0 && !mis;
            m_rd = mem_rd;
            m_mis = mem_valid && mis;
            if (mem_wb_sel == 2'd1)
                m_data = ref_extract(mem_load_data, mem_funct3, off);
            else if (mem_wb_sel == 2'd2)
                m_data = mem_pc_plus4;
            else
                m_data = mem_alu_result;
            if (mem_valid) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input bit rw, input bit [4:0] rd,
                         input bit [1:0] sel, input bit [2:0] f3,
                         input bit [31:0] alu, input bit [31:0] pc4,
                         input bit [31:0] ld);
        mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_result = alu; mem_pc_plus4 = pc4;
        mem_load_data = ld;
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{1,1,5,2'b01,3'b000,32'h1003,32'h0,32'h80FF7F01,
                    32'hFFFFFF80,1,1,1};
        vecs[1] = '{1,1,5,2'b01,3'b100,32'h1003,32'h0,32'h80FF7F01,
                    32'h00000080,1,1,2};
        vecs[2] = '{1,1,6,2'b01,3'b001,32'h2002,32'h0,32'h80011234,
                    32'hFFFF8001,1,1,3};
        vecs[3] = '{1,1,6,2'b01,3'b101,32'h2000,32'h0,32'h80011234,
                    32'h00001234,1,1,4};
        vecs[4] = '{1,1,1,2'b10,3'b000,32'h55,32'h104,32'h0,
                    32'h00000104,1,1,5};
        vecs[5] = '{1,1,0,2'b10,3'b000,32'h55,32'h104,32'h0,
                    32'h00000104,0,1,6};
        vecs[6] = '{1,1,7,2'b00,3'b010,32'h12345678,32'h8,32'hFFFF,
                    32'h12345678,1,1,7};
        vecs[7] = '{1,1,8,2'b11,3'b000,32'hCAFEF00D,32'h8,32'h1,
                    32'hCAFEF00D,1,1,8};
        vecs[8] = '{0,1,3,2'b00,3'b000,32'h600D,32'h0,32'h0,
                    32'h0000600D,0,0,8};
        vecs[9] = '{1,1,9,2'b01,3'b011,32'h0,32'h0,32'hA5A55A5A,
                    32'hA5A55A5A,1,1,9};

        rst = 1; stall = 0; flush = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        m_cnt = 0;
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0, 0);
        rst = 0;
        tick();
        chk_all("idle", 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].valid, vecs[i].rw, vecs[i].rd, vecs[i].sel,
                  vecs[i].f3, vecs[i].alu, vecs[i].pc4, vecs[i].ld);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_rw,
                    vecs[i].rd, vecs[i].exp_data, 0, vecs[i].exp_cnt);
        end

        // stall freezes outputs and counter
        drive(1, 1, 9, 2'b00, 3'b000, 32'hDEADBEEF, 32'h0, 32'h0);
        tick();
        chk_all("alu", 1, 1, 9, 32'hDEADBEEF, 0, 10);
        stall = 1;
        drive(1, 1, 12, 2'b10, 3'b000, 32'h1111, 32'h2222, 32'h3333);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("stall%0d", i), 1, 1, 9, 32'hDEADBEEF, 0, 10);
        end
        flush = 1;
        tick();
        chk_all("stall_flush", 0, 0, 0, 0, 0, 10);
        stall = 0; flush = 0;

        // misaligned LW
        drive(1, 1, 4, 2'b01, 3'b010, 32'h3001, 32'h0, 32'h77665544);
        tick();
`ifdef MEM_WB_MISALIGN_CHECK_EN
        chk_all("mis_lw", 1, 0, 4, 32'h77665544, 1, 11);
`else
        chk_all("mis_lw", 1, 1, 4, 32'h77665544, 0, 11);
`endif
        drive(0, 0, 0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        chk_all("mis_pulse_end", 0, 0, 0, 0, 0, 11);

        // reset mid-stream overrides stall/flush and discards in-flight op
        drive(1, 1, 3, 2'b00, 3'b000, 32'h42, 32'h0, 32'h0);
        rst = 1; stall = 1; flush = 1;
        tick();
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
        rst = 0; stall = 0; flush = 0;
        tick();
        chk_all("rst_mid_after", 1, 1, 3, 32'h42, 0, 1);

        // random traffic vs reference model
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
            tick();
            chk_all($sformatf("rnd%0d", i), m_valid, m_rw, m_rd, m_data,
                    m_mis, m_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
